// File: rtl/chacha_sched_pkg.sv
// Shared types and widths for the ChaCha20 session sequencer.
package chacha_sched_pkg;
  localparam int KEY_W    = 256;
  localparam int NONCE_W  = 64;
  localparam int CTR_W    = 64;
  localparam int BLK_W    = 512;
  localparam int ROUNDS_W = 5;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ISSUE,
    S_WAIT_CORE,
    S_HOLD
  } state_e;
endpackage

// File: rtl/chacha_sched_watchdog.sv
// Core-response watchdog: cleared on issue, counts while waiting, flags the last allowed cycle.
module chacha_sched_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stuck enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/chacha_session_sched.sv
// Session sequencer for the ChaCha20 core: one config, per-block init with self-incremented
// counter, watchdog on the core result, and a valid/ready holding stage toward the divider.
module chacha_session_sched
  import chacha_sched_pkg::*;
#(
  parameter int ROUNDS  = 20,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic                axis_clk,
  input  logic                axis_reset_n,
  input  logic                cfg_valid,
  input  logic [KEY_W-1:0]    cfg_key,
  input  logic [NONCE_W-1:0]  cfg_nonce,
  input  logic [CTR_W-1:0]    cfg_ctr,
  output logic                cfg_ready,
  input  logic                sess_abort,
  input  logic                blk_valid,
  input  logic [BLK_W-1:0]    blk_data,
  input  logic                blk_last,
  output logic                blk_ready,
  output logic                core_init,
  output logic [KEY_W-1:0]    core_key,
  output logic [NONCE_W-1:0]  core_iv,
  output logic [CTR_W-1:0]    core_ctr,
  output logic [ROUNDS_W-1:0] core_rounds,
  output logic [BLK_W-1:0]    core_data_in,
  input  logic [BLK_W-1:0]    core_data_out,
  input  logic                core_data_out_valid,
  output logic                out_valid,
  output logic [BLK_W-1:0]    out_data,
  output logic [CTR_W-1:0]    out_ctr,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_ctr_wrap
);
  state_e               state_q;
  logic [KEY_W-1:0]     key_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [CTR_W-1:0]     ctr_q;
  logic                 exh_q;
  logic [BLK_W-1:0]     blk_q;
  logic                 last_q;
  logic                 cfg_ready_q, blk_ready_q, core_init_q, out_valid_q, out_last_q;
  logic                 busy_q, err_timeout_q, err_ctr_wrap_q;
  logic [CTR_W-1:0]     core_ctr_q, out_ctr_q;
  logic [BLK_W-1:0]     out_data_q;
  logic                 wd_expire;

  chacha_sched_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wd (
    .clk_i    (axis_clk),
    .rst_ni   (axis_reset_n),
    .clr_i    (state_q == S_ISSUE),
    .en_i     (state_q == S_WAIT_CORE),
    .expire_o (wd_expire)
  );

  always_ff @(posedge axis_clk) begin
    if (!axis_reset_n) begin
      state_q        <= S_IDLE;
      key_q          <= '0;
      nonce_q        <= '0;
      ctr_q          <= '0;
      exh_q          <= 1'b0;
      blk_q          <= '0;
      last_q         <= 1'b0;
      cfg_ready_q    <= 1'b0;
      blk_ready_q    <= 1'b0;
      core_init_q    <= 1'b0;
      core_ctr_q     <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_ctr_q      <= '0;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_ctr_wrap_q <= 1'b0;
    end else begin
      core_init_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_ctr_wrap_q <= 1'b0;
      if (sess_abort) begin
        state_q     <= S_IDLE;
        key_q       <= '0;
        out_valid_q <= 1'b0;
        blk_ready_q <= 1'b0;
        cfg_ready_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cfg_ready_q <= 1'b1;
            if (cfg_valid && cfg_ready_q) begin
              key_q       <= cfg_key;
              nonce_q     <= cfg_nonce;
              ctr_q       <= cfg_ctr;
              exh_q       <= 1'b0;
              state_q     <= S_ARMED;
              cfg_ready_q <= 1'b0;
              blk_ready_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
          S_ARMED: begin
            // An exhausted counter must never be reused, so the offer ends the session.
            if (exh_q && blk_valid) begin
              err_ctr_wrap_q <= 1'b1;
              state_q        <= S_IDLE;
              key_q          <= '0;
              blk_ready_q    <= 1'b0;
              cfg_ready_q    <= 1'b1;
              busy_q         <= 1'b0;
            end else if (blk_valid && blk_ready_q) begin
              blk_q       <= blk_data;
              last_q      <= blk_last;
              blk_ready_q <= 1'b0;
              core_init_q <= 1'b1;
              core_ctr_q  <= ctr_q;
              state_q     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            ctr_q   <= ctr_q + CTR_W'(1);
            exh_q   <= (ctr_q == CTR_MAX);
            state_q <= S_WAIT_CORE;
          end
          S_WAIT_CORE: begin
            if (core_data_out_valid) begin
              out_data_q  <= core_data_out;
              out_ctr_q   <= core_ctr_q;
              out_last_q  <= last_q;
              out_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else if (wd_expire) begin
              err_timeout_q <= 1'b1;
              state_q       <= S_IDLE;
              key_q         <= '0;
              cfg_ready_q   <= 1'b1;
              busy_q        <= 1'b0;
            end
          end
          S_HOLD: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (out_last_q) begin
                state_q     <= S_IDLE;
                key_q       <= '0;
                cfg_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end else begin
                state_q     <= S_ARMED;
                blk_ready_q <= ~exh_q;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign blk_ready    = blk_ready_q;
  assign core_init    = core_init_q;
  assign core_key     = key_q;
  assign core_iv      = nonce_q;
  assign core_ctr     = core_ctr_q;
  assign core_rounds  = ROUNDS_W'(ROUNDS);
  assign core_data_in = blk_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_ctr      = out_ctr_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign err_timeout  = err_timeout_q;
  assign err_ctr_wrap = err_ctr_wrap_q;
endmodule

// File: tb/tb_chacha_session_sched.sv
// Directed bench for chacha_session_sched with a fixed-latency stand-in core.
module tb_chacha_session_sched;
  import chacha_sched_pkg::*;

  logic               axis_clk = 1'b0;
  logic               axis_reset_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [KEY_W-1:0]   cfg_key = '0;
  logic [NONCE_W-1:0] cfg_nonce = '0;
  logic [CTR_W-1:0]   cfg_ctr = '0;
  logic               cfg_ready;
  logic               sess_abort = 1'b0;
  logic               blk_valid = 1'b0;
  logic [BLK_W-1:0]   blk_data = '0;
  logic               blk_last = 1'b0;
  logic               blk_ready;
  logic               core_init;
  logic [KEY_W-1:0]   core_key;
  logic [NONCE_W-1:0] core_iv;
  logic [CTR_W-1:0]   core_ctr;
  logic [4:0]         core_rounds;
  logic [BLK_W-1:0]   core_data_in;
  logic [BLK_W-1:0]   core_data_out = '0;
  logic               core_data_out_valid = 1'b0;
  logic               out_valid;
  logic [BLK_W-1:0]   out_data;
  logic [CTR_W-1:0]   out_ctr;
  logic               out_last;
  logic               out_ready = 1'b0;
  logic               busy, err_timeout, err_ctr_wrap;

  int vecs = 0;
  int errs = 0;
  logic core_resp = 1'b1;

  chacha_session_sched #(.ROUNDS(20), .TIMEOUT(64), .TO_W(7)) dut (
    .axis_clk(axis_clk), .axis_reset_n(axis_reset_n),
    .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce), .cfg_ctr(cfg_ctr),
    .cfg_ready(cfg_ready), .sess_abort(sess_abort),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last), .blk_ready(blk_ready),
    .core_init(core_init), .core_key(core_key), .core_iv(core_iv), .core_ctr(core_ctr),
    .core_rounds(core_rounds), .core_data_in(core_data_in),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
    .out_valid(out_valid), .out_data(out_data), .out_ctr(out_ctr), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .err_timeout(err_timeout), .err_ctr_wrap(err_ctr_wrap)
  );

  always #5 axis_clk = ~axis_clk;

  // Stand-in core: result = data ^ replicated counter, valid raised 21 cycles after init.
  initial begin : core_model
    logic             pend;
    int               cnt;
    logic [BLK_W-1:0] res;
    pend = 1'b0; cnt = 0; res = '0;
    forever begin
      @(negedge axis_clk);
      if (core_init === 1'b1) begin
        core_data_out_valid = 1'b0;
        pend = 1'b1;
        cnt  = 0;
        res  = core_data_in ^ {8{core_ctr}};
      end else if (pend) begin
        cnt++;
        if (cnt == 21 && core_resp) begin
          core_data_out       = res;
          core_data_out_valid = 1'b1;
          pend                = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send_cfg(input logic [KEY_W-1:0] k, input logic [NONCE_W-1:0] n,
                          input logic [CTR_W-1:0] c);
    int w = 0;
    while (cfg_ready !== 1'b1 && w < 50) begin tick(); w++; end
    vecs++;
    if (cfg_ready !== 1'b1) begin errs++; $display("FAIL cfg_ready_wait: got %b want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_key = k; cfg_nonce = n; cfg_ctr = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [BLK_W-1:0] d, input logic l);
    int w = 0;
    while (blk_ready !== 1'b1 && w < 50) begin tick(); w++; end
    vecs++;
    if (blk_ready !== 1'b1) begin errs++; $display("FAIL blk_ready_wait: got %b want 1", blk_ready); end
    blk_valid = 1'b1; blk_data = d; blk_last = l;
    tick();
    blk_valid = 1'b0; blk_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    vecs++;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL out_valid_wait: got %b want 1", out_valid); end
  endtask

  task automatic do_hs();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    vecs++;
    if ({cfg_ready, blk_ready, core_init, out_valid, busy, err_timeout, err_ctr_wrap} !== 7'b0) begin
      errs++; $display("FAIL rst_flags: got %b want 0",
        {cfg_ready, blk_ready, core_init, out_valid, busy, err_timeout, err_ctr_wrap});
    end
    vecs++;
    if (core_rounds !== 5'd20) begin errs++; $display("FAIL rst_rounds: got %0d want 20", core_rounds); end
    vecs++;
    if (core_key !== '0 || core_ctr !== '0 || out_ctr !== '0) begin
      errs++; $display("FAIL rst_regs: key %h ctr %h out_ctr %h want 0", core_key, core_ctr, out_ctr);
    end
    axis_reset_n = 1'b1;
    tick();
    vecs++;
    if (cfg_ready !== 1'b1) begin errs++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_nominal();
    logic [KEY_W-1:0] k;
    logic [BLK_W-1:0] d;
    logic [CTR_W-1:0] c;
    int n;
    for (int i = 0; i < 32; i++) k[255-8*i -: 8] = 8'(i);
    send_cfg(k, 64'h0000_004A_0000_0000, 64'd1);
    for (int b = 0; b < 3; b++) begin
      d = {16{32'hB10C_0000 + 32'(b)}};
      c = 64'(1 + b);
      send_blk(d, b == 2);
      vecs++;
      if (core_init !== 1'b1 || core_ctr !== c) begin
        errs++; $display("FAIL nom_init: init %b ctr %0h want 1 %0h", core_init, core_ctr, c);
      end
      vecs++;
      if (core_key !== k || core_iv !== 64'h0000_004A_0000_0000 || core_data_in !== d) begin
        errs++; $display("FAIL nom_core_regs: key %h iv %h want %h 4a00000000", core_key, core_iv, k);
      end
      tick();
      vecs++;
      if (core_init !== 1'b0) begin errs++; $display("FAIL nom_init_pulse: got %b want 0", core_init); end
      wait_out(n);
      vecs++;
      if (n != 21) begin errs++; $display("FAIL nom_latency: got %0d want 21", n); end
      vecs++;
      if (out_data !== (d ^ {8{c}}) || out_ctr !== c || out_last !== (b == 2)) begin
        errs++; $display("FAIL nom_out: ctr %0h last %b want %0h %b", out_ctr, out_last, c, b == 2);
      end
      do_hs();
      vecs++;
      if (b == 2) begin
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || core_key !== '0) begin
          errs++; $display("FAIL nom_end: busy %b cfg_ready %b key %h want 0 1 0", busy, cfg_ready, core_key);
        end
      end else if (out_valid !== 1'b0 || blk_ready !== 1'b1) begin
        errs++; $display("FAIL nom_next: out_valid %b blk_ready %b want 0 1", out_valid, blk_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BLK_W-1:0] d;
    int n;
    d = {8{64'hDEAD_BEEF_0123_4567}};
    send_cfg({8{32'hA5A5_5A5A}}, 64'h1234, 64'h10);
    send_blk(d, 1'b0);
    wait_out(n);
    blk_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_data !== (d ^ {8{64'h10}}) || out_ctr !== 64'h10 || blk_ready !== 1'b0) begin
        errs++; $display("FAIL bp_hold[%0d]: valid %b ctr %0h blk_ready %b want 1 10 0",
                         i, out_valid, out_ctr, blk_ready);
      end
      tick();
    end
    blk_valid = 1'b0;
    do_hs();
    vecs++;
    if (out_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL bp_release: valid %b blk_ready %b busy %b want 0 1 1", out_valid, blk_ready, busy);
    end
    sess_abort = 1'b1;
    tick();
    sess_abort = 1'b0;
  endtask

  task automatic test_ctr_wrap();
    logic [BLK_W-1:0] d;
    int n;
    d = {16{32'h0F0F_1234}};
    send_cfg({8{32'h1111_2222}}, 64'h77, CTR_MAX);
    send_blk(d, 1'b0);
    vecs++;
    if (core_ctr !== CTR_MAX) begin errs++; $display("FAIL wrap_issue: got %h want ffffffffffffffff", core_ctr); end
    tick();
    wait_out(n);
    vecs++;
    if (out_ctr !== CTR_MAX) begin errs++; $display("FAIL wrap_out_ctr: got %h want all ones", out_ctr); end
    do_hs();
    tick();
    vecs++;
    if (blk_ready !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL wrap_blocked: blk_ready %b busy %b want 0 1", blk_ready, busy);
    end
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    vecs++;
    if (err_ctr_wrap !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1 || core_init !== 1'b0) begin
      errs++; $display("FAIL wrap_err: err %b busy %b cfg_ready %b init %b want 1 0 1 0",
                       err_ctr_wrap, busy, cfg_ready, core_init);
    end
    tick();
    vecs++;
    if (err_ctr_wrap !== 1'b0) begin errs++; $display("FAIL wrap_pulse: got %b want 0", err_ctr_wrap); end
  endtask

  task automatic test_timeout();
    int n = 0;
    core_resp = 1'b0;
    send_cfg({8{32'hCAFE_F00D}}, 64'h5, 64'h9);
    send_blk({16{32'h5555_AAAA}}, 1'b0);
    while (err_timeout !== 1'b1 && n < 200) begin tick(); n++; end
    vecs++;
    if (n != 65) begin errs++; $display("FAIL to_cycle: got %0d want 65", n); end
    vecs++;
    if (busy !== 1'b0 || core_key !== '0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL to_idle: busy %b key %h valid %b want 0 0 0", busy, core_key, out_valid);
    end
    tick();
    vecs++;
    if (err_timeout !== 1'b0) begin errs++; $display("FAIL to_pulse: got %b want 0", err_timeout); end
    core_resp = 1'b1;
  endtask

  task automatic test_abort();
    send_cfg({8{32'h0BAD_C0DE}}, 64'h6, 64'h20);
    send_blk({16{32'h1357_9BDF}}, 1'b1);
    repeat (5) tick();
    sess_abort = 1'b1;
    tick();
    sess_abort = 1'b0;
    vecs++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || core_key !== '0 || cfg_ready !== 1'b1) begin
      errs++; $display("FAIL ab_idle: busy %b valid %b key %h cfg_ready %b want 0 0 0 1",
                       busy, out_valid, core_key, cfg_ready);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      vecs++;
      if ({out_valid, err_timeout, err_ctr_wrap} !== 3'b0) begin
        errs++; $display("FAIL ab_quiet[%0d]: got %b want 000", i, {out_valid, err_timeout, err_ctr_wrap});
      end
    end
    cfg_valid = 1'b1; cfg_key = {8{32'h9999_9999}}; sess_abort = 1'b1;
    tick();
    cfg_valid = 1'b0; sess_abort = 1'b0;
    vecs++;
    if (busy !== 1'b0 || core_key !== '0) begin
      errs++; $display("FAIL ab_cfg: busy %b key %h want 0 0", busy, core_key);
    end
  endtask

  task automatic test_reset_hold();
    int n;
    send_cfg({8{32'h4242_4242}}, 64'h8, 64'h30);
    send_blk({16{32'h2468_ACE0}}, 1'b0);
    tick();
    wait_out(n);
    axis_reset_n = 1'b0;
    tick();
    vecs++;
    if ({cfg_ready, blk_ready, core_init, out_valid, out_last, busy, err_timeout, err_ctr_wrap} !== 8'b0) begin
      errs++; $display("FAIL rh_flags: got %b want 0",
        {cfg_ready, blk_ready, core_init, out_valid, out_last, busy, err_timeout, err_ctr_wrap});
    end
    vecs++;
    if (core_key !== '0 || core_iv !== '0 || core_ctr !== '0 || out_ctr !== '0 ||
        out_data !== '0 || core_data_in !== '0 || core_rounds !== 5'd20) begin
      errs++; $display("FAIL rh_regs: key %h iv %h ctr %h out_ctr %h rounds %0d want 0 0 0 0 20",
                       core_key, core_iv, core_ctr, out_ctr, core_rounds);
    end
    axis_reset_n = 1'b1;
    tick();
    vecs++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL rh_release: cfg_ready %b busy %b want 1 0", cfg_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_ctr_wrap();
    test_timeout();
    test_abort();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
